// File: rtl/et_err_pkg.sv
// et_err_pkg: shared state encodings, defaults and header-code helper for the error-bus mux
package et_err_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam int DEF_HDR_BASE   = 4;
  localparam int DEF_LENGTH_ERR = 232;
  function automatic int hdr_code(input int k, input int base = DEF_HDR_BASE);
    return base + k;
  endfunction
endpackage

// File: rtl/et_err_ch.sv
// et_err_ch: one channel's capture FSM, payload register and got/dup/parity flags
//   clk, in_live (async active-low reset), in_err (serial bit), hit (header matched, arbiter idle),
//   bypass (force done), rearm (clear), cnt (shared bit index) -> cap/cap_nxt (capture now/next),
//   got, dup, bus (LENGTH_ERR payload bits), par_err when ET_ERR_PARITY_EN is defined
module et_err_ch
  import et_err_pkg::*;
#(
  parameter int LENGTH_ERR = DEF_LENGTH_ERR,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  in_live,
  input  logic                  in_err,
  input  logic                  hit,
  input  logic                  bypass,
  input  logic                  rearm,
  input  logic [CNT_W-1:0]      cnt,
  output logic                  cap,
  output logic                  cap_nxt,
  output logic                  got,
  output logic                  dup,
  output logic [LENGTH_ERR-1:0] bus
`ifdef ET_ERR_PARITY_EN
  ,output logic                 par_err
`endif
);
`ifdef ET_ERR_PARITY_EN
  localparam int LEN_TOT = LENGTH_ERR + 1;
`else
  localparam int LEN_TOT = LENGTH_ERR;
`endif
  logic [1:0] st, st_d;
  logic wr, last;
  // the header cycle itself carries payload bit 0, so a starting channel writes too
  always_comb begin
    cap     = st == ST_CAPTURE;
    wr      = (hit && st == ST_IDLE) || cap;
    last    = wr && cnt == CNT_W'(LEN_TOT - 1);
    st_d    = bypass ? ST_DONE : rearm ? ST_IDLE : (hit && st == ST_IDLE) ? ST_CAPTURE : last ? ST_DONE : st;
    cap_nxt = st_d == ST_CAPTURE;
  end
  always_ff @(posedge clk or negedge in_live) begin
    if (!in_live) begin
      st  <= ST_IDLE;
      got <= 1'b0;
      dup <= 1'b0;
      bus <= '0;
`ifdef ET_ERR_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      st  <= st_d;
      got <= bypass | (~rearm & (got | last));
      dup <= ~rearm & (dup | (hit && st == ST_DONE));
      if (rearm) bus <= '0;
      else if (!bypass && wr && cnt < CNT_W'(LENGTH_ERR)) bus[cnt] <= in_err;
`ifdef ET_ERR_PARITY_EN
      par_err <= ~rearm & (par_err | (last & ~bypass & (^bus ^ in_err)));
`endif
    end
  end
endmodule

// File: rtl/et_err_mux.sv
// et_err_mux: serial error-bus deserialiser with NUM_CH header-addressed channels
//   clk, in_live (async active-low reset), in_err (serial stream), bypass[NUM_CH] (force done),
//   in_rearm (sync clear) -> got_err_bus[NUM_CH], out_err_bus[NUM_CH*LENGTH_ERR], busy, dup_hdr[NUM_CH]
//   ET_ERR_PARITY_EN: adds an even-parity bit per frame and the par_err[NUM_CH] output
module et_err_mux
  import et_err_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int HDR_W      = 3,
  parameter int HDR_BASE   = DEF_HDR_BASE,
  parameter int LENGTH_ERR = DEF_LENGTH_ERR,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         in_live,
  input  logic                         in_err,
  input  logic [NUM_CH-1:0]            bypass,
  input  logic                         in_rearm,
  output logic [NUM_CH-1:0]            got_err_bus,
  output logic [NUM_CH*LENGTH_ERR-1:0] out_err_bus,
  output logic                         busy,
  output logic [NUM_CH-1:0]            dup_hdr
`ifdef ET_ERR_PARITY_EN
  ,output logic [NUM_CH-1:0]           par_err
`endif
);
  logic [HDR_W-1:0]  sr;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] cap, cap_nxt, hit;
  // busy covers the header cycle too, since that cycle already carries payload bit 0
  assign busy = |cap | |cap_nxt;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // headers are ignored while any frame is in flight, so payload bits never re-trigger
    assign hit[k] = !(|cap) && !in_rearm && sr == HDR_W'(hdr_code(k, HDR_BASE));
    et_err_ch #(.LENGTH_ERR(LENGTH_ERR), .CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .in_live (in_live),
      .in_err  (in_err),
      .hit     (hit[k]),
      .bypass  (bypass[k]),
      .rearm   (in_rearm),
      .cnt     (cnt),
      .cap     (cap[k]),
      .cap_nxt (cap_nxt[k]),
      .got     (got_err_bus[k]),
      .dup     (dup_hdr[k]),
      .bus     (out_err_bus[k*LENGTH_ERR +: LENGTH_ERR])
`ifdef ET_ERR_PARITY_EN
      ,.par_err(par_err[k])
`endif
    );
  end
  always_ff @(posedge clk or negedge in_live) begin
    if (!in_live) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= {sr[HDR_W-2:0], in_err};
      cnt <= |cap_nxt ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_et_err_mux.sv
module tb_et_err_mux;
  localparam int L = 232;
  logic clk = 0, in_live = 0, in_err = 0, in_rearm = 0, busy;
  logic [1:0] bypass = 0, got_err_bus, dup_hdr;
  logic [2*L-1:0] out_err_bus;
`ifdef ET_ERR_PARITY_EN
  logic [1:0] par_err;
`endif
  int n_pass = 0, n_tot = 0;
  typedef struct {
    logic err; logic [1:0] byp; logic rm;
    logic [1:0] got; logic [1:0] dup; logic busy;
  } vec_t;
  vec_t tbl[18];
  logic [L-1:0] pa, pb, pc, ones;
  int bc;

  always #5 clk = ~clk;

  et_err_mux dut (
    .clk(clk), .in_live(in_live), .in_err(in_err), .bypass(bypass), .in_rearm(in_rearm),
    .got_err_bus(got_err_bus), .out_err_bus(out_err_bus), .busy(busy), .dup_hdr(dup_hdr)
`ifdef ET_ERR_PARITY_EN
    , .par_err(par_err)
`endif
  );

  task automatic chk(input string nm, input logic [2*L-1:0] act, input logic [2*L-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic b);
    in_err = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #3;
    in_live = 0; in_err = 0; bypass = 0; in_rearm = 0;
    #12;
    in_live = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [2:0] h, inout int cnt);
    for (int i = 2; i >= 0; i--) begin
      cnt += int'(busy);
      send(h[i]);
    end
  endtask

  task automatic send_pl(input logic [L-1:0] pl, input int lo, input int hi, inout int cnt);
    for (int i = lo; i <= hi; i++) begin
      cnt += int'(busy);
      send(pl[i]);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 2'b10, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 1'b0};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 2'b11, 2'b10, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, 1'b0, 2'b11, 2'b11, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{1'b0, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0};
    tbl[11] = '{1'b1, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
    tbl[14] = '{1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
    tbl[15] = '{1'b0, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0};
    tbl[16] = '{1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0};
    tbl[17] = '{1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0};
    for (int i = 0; i < L; i++) begin
      pa[i] = (i % 2) == 0;
      pb[i] = (i % 3) == 0;
      pc[i] = (i < L - 3) && (i % 7) == 3;
    end
    ones = '1;

    // reset state, then a full channel-0 frame with alternating payload
    do_reset;
    chk("rst_got", got_err_bus, 0);
    chk("rst_dup", dup_hdr, 0);
    chk("rst_bus", out_err_bus, 0);
    chk("rst_busy", busy, 0);
    bc = 0;
    send_hdr(3'b100, bc);
    send_pl(pa, 0, L - 2, bc);
    chk("a_got_before_last", got_err_bus, 2'b00);
    send_pl(pa, L - 1, L - 1, bc);
    chk("a_got", got_err_bus, 2'b01);
    chk("a_bus", out_err_bus, {{L{1'b0}}, pa});
    chk("a_busy_cycles", bc, 232);
    chk("a_busy_after", busy, 0);
    chk("a_dup", dup_hdr, 0);

    // channel 1 with all-ones payload
    do_reset;
    bc = 0;
    send_hdr(3'b101, bc);
    send_pl(ones, 0, L - 1, bc);
    chk("b1_got", got_err_bus, 2'b10);
    chk("b1_bus", out_err_bus, {ones, {L{1'b0}}});

    // channel 1 payload full of 1,0,0 runs must not start channel 0
    do_reset;
    bc = 0;
    send_hdr(3'b101, bc);
    send_pl(pb, 0, L - 1, bc);
    chk("b2_got", got_err_bus, 2'b10);
    chk("b2_bus", out_err_bus, {pb, {L{1'b0}}});
    chk("b2_dup", dup_hdr, 0);
    chk("b2_busy_cycles", bc, 232);

    // duplicate header on a completed channel
    do_reset;
    bc = 0;
    send_hdr(3'b100, bc);
    send_pl(pc, 0, L - 1, bc);
    chk("c_got", got_err_bus, 2'b01);
    bc = 0;
    send_hdr(3'b100, bc);
    bc += int'(busy);
    send(1'b0);
    bc += int'(busy);
    chk("c_dup", dup_hdr, 2'b01);
    chk("c_bus", out_err_bus, {{L{1'b0}}, pc});
    chk("c_busy_cycles", bc, 0);
    chk("c_got_held", got_err_bus, 2'b01);

    // rearm in the middle of a frame, then a clean frame
    do_reset;
    bc = 0;
    send_hdr(3'b100, bc);
    send_pl(pa, 0, 99, bc);
    in_rearm = 1;
    send(pa[100]);
    chk("d_busy", busy, 0);
    chk("d_got", got_err_bus, 0);
    chk("d_bus", out_err_bus, 0);
    send(1'b0);
    send(1'b0);
    send(1'b0);
    in_rearm = 0;
    bc = 0;
    send_hdr(3'b100, bc);
    send_pl(pa, 0, L - 1, bc);
    chk("d_got2", got_err_bus, 2'b01);
    chk("d_bus2", out_err_bus, {{L{1'b0}}, pa});

    // async reset mid-frame
    do_reset;
    bc = 0;
    send_hdr(3'b100, bc);
    send_pl(pa, 0, 49, bc);
    #3;
    in_live = 0;
    #1;
    chk("f_got", got_err_bus, 0);
    chk("f_busy", busy, 0);
    chk("f_bus", out_err_bus, 0);
    chk("f_dup", dup_hdr, 0);
    #10;
    in_live = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 240; i++) send(1'b0);
    chk("f_got_after", got_err_bus, 0);
    chk("f_bus_after", out_err_bus, 0);
    chk("f_busy_after", busy, 0);

    // cycle-by-cycle bypass / dup / rearm table
    do_reset;
    for (int i = 0; i < 18; i++) begin
      in_err = tbl[i].err;
      bypass = tbl[i].byp;
      in_rearm = tbl[i].rm;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_got", i), got_err_bus, tbl[i].got);
      chk($sformatf("t%0d_dup", i), dup_hdr, tbl[i].dup);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
    end
    bypass = 0;
    in_rearm = 0;
    chk("t_abort_bus", out_err_bus, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
